// File: rtl/seg_display_ctrl.sv
// Front-end for the seven-segment scanner: scan strobe prescaler, debounced
// source-select and freeze buttons, and a periodically refreshed display snapshot.

module seg_btn_debounce #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          state;
  logic [DW-1:0] cnt;

  // NOTE: all state here is updated with <= so every flop samples pre-edge values
  // regardless of statement order; blocking = would chain sync1 straight into sync2.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        state <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module seg_display_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int DEBOUNCE = 250000,
  parameter int SNAP_DIV = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] pcval,
  input  logic [31:0] instr,
  input  logic [15:0] aluval,
  input  logic        btn_next,
  input  logic        btn_freeze,
  output logic        scan_en,
  output logic [15:0] dispval,
  output logic [1:0]  srcsel,
  output logic        frozen
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (SNAP_DIV > 1) ? $clog2(SNAP_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SNAP_LAST = SW'(SNAP_DIV - 1);

  logic [PW-1:0] ps_cnt;
  logic [SW-1:0] snap_cnt;
  logic          press_next;
  logic          press_freeze;
  logic          sel_load;
  logic          snap_event;
  logic [15:0]   src_mux;

  seg_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_next (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (btn_next),
    .press   (press_next)
  );

  seg_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_freeze (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (btn_freeze),
    .press   (press_freeze)
  );

  always_comb begin
    src_mux = pcval;
    case (srcsel)
      2'd0: src_mux = pcval;
      2'd1: src_mux = instr[15:0];
      2'd2: src_mux = instr[31:16];
      2'd3: src_mux = aluval;
      default: src_mux = pcval;
    endcase
  end

  assign snap_event = scan_en && (snap_cnt == SNAP_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt   <= '0;
      scan_en  <= 1'b0;
      snap_cnt <= '0;
      srcsel   <= 2'd0;
      frozen   <= 1'b0;
      sel_load <= 1'b0;
      dispval  <= 16'h0000;
    end else begin
      scan_en <= (ps_cnt == PS_LAST);
      ps_cnt  <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;

      if (scan_en) begin
        snap_cnt <= (snap_cnt == SNAP_LAST) ? '0 : snap_cnt + 1'b1;
      end

      srcsel   <= srcsel + {1'b0, press_next};
      frozen   <= frozen ^ press_freeze;
      sel_load <= press_next;

      // A snapshot coinciding with a next-press is folded into the reload that
      // follows one cycle later, so only the new source ever reaches the display.
      if (sel_load || (snap_event && !frozen && !press_next)) begin
        dispval <= src_mux;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized bench for seg_display_ctrl against a cycle-level behavioural model
// built from absolute cycle counts and debounce run lengths.

module tb_seg_display_ctrl;

  localparam int P   = 4;
  localparam int DEB = 3;
  localparam int S   = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] pcval;
  logic [31:0] instr;
  logic [15:0] aluval;
  logic        btn_next;
  logic        btn_freeze;
  logic        scan_en;
  logic [15:0] dispval;
  logic [1:0]  srcsel;
  logic        frozen;

  int vectors     = 0;
  int miscompares = 0;

  // model state
  int          n;
  logic        e_scan;
  logic [1:0]  e_sel;
  logic        e_frz;
  logic [15:0] e_disp;
  logic        sel_load_pending;
  logic        raw_d1[2];
  logic        raw_d2[2];
  logic        level[2];
  int          disagree[2];
  logic        pulse[2];

  seg_display_ctrl #(.PRESCALE(P), .DEBOUNCE(DEB), .SNAP_DIV(S)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pcval      (pcval),
    .instr      (instr),
    .aluval     (aluval),
    .btn_next   (btn_next),
    .btn_freeze (btn_freeze),
    .scan_en    (scan_en),
    .dispval    (dispval),
    .srcsel     (srcsel),
    .frozen     (frozen)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_src(input logic [1:0] s);
    case (s)
      2'd0:    return pcval;
      2'd1:    return instr[15:0];
      2'd2:    return instr[31:16];
      default: return aluval;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec();
    return {e_scan, e_sel, e_frz, e_disp};
  endfunction

  task automatic model_reset();
    n = 0;
    e_scan = 1'b0;
    e_sel = 2'd0;
    e_frz = 1'b0;
    e_disp = 16'h0000;
    sel_load_pending = 1'b0;
    for (int b = 0; b < 2; b++) begin
      raw_d1[b] = 1'b0;
      raw_d2[b] = 1'b0;
      level[b] = 1'b0;
      disagree[b] = 0;
      pulse[b] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge (n counts edges since reset release).
  task automatic model_step();
    logic snap;
    logic load;
    logic raw_now[2];
    n++;
    // cycle n-1 carried a strobe if n-1 is a positive multiple of P; every S-th strobe snapshots
    snap = ((n - 1) > 0) && ((n - 1) % P == 0) && (((n - 1) / P) % S == 0);
    load = (snap && !e_frz && !pulse[0]) || sel_load_pending;
    if (load) e_disp = m_src(e_sel);
    sel_load_pending = pulse[0];
    if (pulse[0]) e_sel = e_sel + 2'd1;
    if (pulse[1]) e_frz = !e_frz;
    e_scan = (n % P == 0);
    raw_now[0] = btn_next;
    raw_now[1] = btn_freeze;
    for (int b = 0; b < 2; b++) begin
      // raw_d2 is the raw level sampled two edges ago, i.e. the synchronized value
      pulse[b] = 1'b0;
      if (raw_d2[b] != level[b]) begin
        if (disagree[b] == DEB - 1) begin
          level[b] = raw_d2[b];
          disagree[b] = 0;
          pulse[b] = raw_d2[b];
        end else begin
          disagree[b]++;
        end
      end else begin
        disagree[b] = 0;
      end
      raw_d2[b] = raw_d1[b];
      raw_d1[b] = raw_now[b];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pcval = '0; instr = '0; aluval = '0;
    btn_next = 1'b0; btn_freeze = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    vectors++;
    if ({scan_en, srcsel, frozen, dispval} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got {scan,sel,frz,disp}=%h want 00000",
               {scan_en, srcsel, frozen, dispval});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_strobe cyc %0d: got {scan,sel,frz,disp}=%h want %h",
                 n, {scan_en, srcsel, frozen, dispval}, exp_vec());
      end
    end
  endtask

  task automatic test_snapshot();
    pcval = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
        miscompares++;
        $display("FAIL snapshot_1234 cyc %0d: got %h want %h",
                 n, {scan_en, srcsel, frozen, dispval}, exp_vec());
      end
    end
    pcval = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
        miscompares++;
        $display("FAIL snapshot_beef cyc %0d: got %h want %h",
                 n, {scan_en, srcsel, frozen, dispval}, exp_vec());
      end
    end
  endtask

  task automatic test_source_cycle();
    instr = 32'hCAFE_F00D;
    aluval = 16'h00A5;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        btn_next = (i < 8);
        tick();
        vectors++;
        if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
          miscompares++;
          $display("FAIL source_cycle press %0d cyc %0d: got %h want %h",
                   p, n, {scan_en, srcsel, frozen, dispval}, exp_vec());
        end
      end
    end
    btn_next = 1'b0;
  endtask

  task automatic test_debounce();
    logic [1:0] sel_before;
    sel_before = e_sel;
    for (int i = 0; i < 26; i++) begin
      if (i < 10)      btn_next = (i % 2 == 0);
      else if (i < 16) btn_next = 1'b0;
      else if (i < 18) btn_next = 1'b1;
      else             btn_next = 1'b0;
      tick();
      vectors++;
      if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
        miscompares++;
        $display("FAIL debounce cyc %0d: got %h want %h",
                 n, {scan_en, srcsel, frozen, dispval}, exp_vec());
      end
    end
    vectors++;
    if (srcsel !== sel_before) begin
      miscompares++;
      $display("FAIL debounce_sel: got srcsel=%0d want %0d", srcsel, sel_before);
    end
  endtask

  task automatic test_freeze();
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 30; i++) begin
        btn_freeze = (ph == 0 || ph == 2) && (i < 8);
        btn_next   = (ph == 1) && (i < 8);
        pcval  = 16'($urandom);
        instr  = $urandom;
        aluval = 16'($urandom);
        tick();
        vectors++;
        if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
          miscompares++;
          $display("FAIL freeze phase %0d cyc %0d: got %h want %h",
                   ph, n, {scan_en, srcsel, frozen, dispval}, exp_vec());
        end
      end
    end
    btn_freeze = 1'b0;
    btn_next = 1'b0;
  endtask

  task automatic test_random();
    int hold_next = 0;
    int hold_frz = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold_next == 0) begin
        btn_next = 1'($urandom);
        hold_next = $urandom_range(1, 7);
      end
      if (hold_frz == 0) begin
        btn_freeze = 1'($urandom);
        hold_frz = $urandom_range(1, 9);
      end
      hold_next--;
      hold_frz--;
      if ($urandom_range(0, 3) == 0) pcval = 16'($urandom);
      if ($urandom_range(0, 3) == 0) instr = $urandom;
      if ($urandom_range(0, 3) == 0) aluval = 16'($urandom);
      tick();
      vectors++;
      if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h want %h",
                 n, {scan_en, srcsel, frozen, dispval}, exp_vec());
      end
    end
    btn_next = 1'b0;
    btn_freeze = 1'b0;
  endtask

  task automatic test_mid_reset();
    int first_scan;
    int budget;
    budget = 0;
    while ((e_sel != 2'd2 || !e_frz) && budget < 600) begin
      for (int i = 0; i < 12; i++) begin
        btn_next   = (e_sel != 2'd2) && (i < 6);
        btn_freeze = (e_frz == 1'b0) && (e_sel == 2'd2) && (i < 6);
        tick();
        budget++;
        vectors++;
        if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
          miscompares++;
          $display("FAIL mid_reset_setup cyc %0d: got %h want %h",
                   n, {scan_en, srcsel, frozen, dispval}, exp_vec());
        end
      end
    end
    btn_next = 1'b0;
    btn_freeze = 1'b0;
    budget = 0;
    while (n % P != 2 && budget < 2 * P) begin
      tick();
      budget++;
    end
    vectors++;
    if (srcsel !== 2'd2 || frozen !== 1'b1 || n % P != 2) begin
      miscompares++;
      $display("FAIL mid_reset_precondition: got srcsel=%0d frozen=%b phase=%0d want 2 1 2",
               srcsel, frozen, n % P);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({scan_en, srcsel, frozen, dispval} !== 20'h0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got {scan,sel,frz,disp}=%h want 00000",
               {scan_en, srcsel, frozen, dispval});
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    first_scan = 0;
    for (int i = 1; i <= 2 * P; i++) begin
      tick();
      if (scan_en === 1'b1 && first_scan == 0) first_scan = i;
      vectors++;
      if ({scan_en, srcsel, frozen, dispval} !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_reset_recover cyc %0d: got %h want %h",
                 n, {scan_en, srcsel, frozen, dispval}, exp_vec());
      end
    end
    vectors++;
    if (first_scan != P) begin
      miscompares++;
      $display("FAIL mid_reset_first_scan: got cycle %0d want %0d", first_scan, P);
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_source_cycle();
    test_debounce();
    test_freeze();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
